// File: rtl/ssram_master.sv
// ---------------------------------------------------------------------------
// ssram_master
//   Bus master for the one-hot row/column addressed register array.
//   A host request (binary address, read/write, write data) becomes a fixed
//   four-state access: IDLE -> SEL -> XFER -> GAP -> IDLE. The array enables
//   its cells one cycle after selection, so selection is held for two cycles
//   (SEL, XFER). The access completes on the XFER closing edge. GAP deselects
//   everything so the array's enable delay clears between accesses.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req, wr       request and direction (1 = write), sampled only in IDLE
//   addr          register index: addr[7:4] row, addr[3:0] column
//   wdata         write data, latched with the request
//   rdata         last read data, registered, held until the next read
//   busy          high whenever the FSM is not in IDLE
//   done          one-cycle completion pulse (GAP cycle)
//   err           one-cycle pulse with done when addr >= DEPTH
//   row, column   registered one-hot selects to the array
//   we, re        registered write/read strobes to the array
//   data          shared tri-state data bus; driven only during write SEL/XFER
// ---------------------------------------------------------------------------
module ssram_master #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wr,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      row,
  output logic [15:0]      column,
  output logic             we,
  output logic             re,
  inout  wire  [WIDTH-1:0] data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      row_nxt;
  logic [15:0]      column_nxt;
  logic             we_nxt;
  logic             re_nxt;
  logic             oe_q;
  logic             oe_nxt;
  logic             wr_q;
  logic             wr_nxt;
  logic             invalid_q;
  logic             invalid_nxt;
  logic [WIDTH-1:0] rdata_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic             load_wdata;
  logic [WIDTH-1:0] wdata_q;
  logic             addr_ok;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    logic [15:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Widen before comparing so DEPTH = 256 never flags an address as invalid.
  assign addr_ok = ({24'd0, addr} < 32'(DEPTH));

  assign busy = (state != IDLE);

  // The bus is released whenever the registered output enable is low; the
  // enable itself is only ever set for writes.
  assign data = oe_q ? wdata_q : {WIDTH{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    column_nxt  = column;
    we_nxt      = we;
    re_nxt      = re;
    oe_nxt      = oe_q;
    wr_nxt      = wr_q;
    invalid_nxt = invalid_q;
    rdata_nxt   = rdata;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    load_wdata  = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt   = SEL;
          wr_nxt      = wr;
          invalid_nxt = !addr_ok;
          // Out-of-range addresses still run the full access but select
          // nothing, so no register can be touched.
          row_nxt     = addr_ok ? onehot16(addr[7:4]) : 16'h0000;
          column_nxt  = addr_ok ? onehot16(addr[3:0]) : 16'h0000;
          we_nxt      = wr;
          re_nxt      = !wr;
          oe_nxt      = wr;
          load_wdata  = 1'b1;
        end
      end

      SEL: begin
        state_nxt = XFER;
      end

      XFER: begin
        state_nxt  = GAP;
        // Read data is only valid on the bus during XFER, after the array's
        // enable delay has risen.
        if (!wr_q) begin
          rdata_nxt = invalid_q ? '0 : data;
        end
        row_nxt    = 16'h0000;
        column_nxt = 16'h0000;
        we_nxt     = 1'b0;
        re_nxt     = 1'b0;
        oe_nxt     = 1'b0;
        done_nxt   = 1'b1;
        err_nxt    = invalid_q;
      end

      GAP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus-side and host-side registers: everything the array or host sees
  // comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= 16'h0000;
      column    <= 16'h0000;
      we        <= 1'b0;
      re        <= 1'b0;
      oe_q      <= 1'b0;
      wr_q      <= 1'b0;
      invalid_q <= 1'b0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      row       <= row_nxt;
      column    <= column_nxt;
      we        <= we_nxt;
      re        <= re_nxt;
      oe_q      <= oe_nxt;
      wr_q      <= wr_nxt;
      invalid_q <= invalid_nxt;
      rdata     <= rdata_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Write data is only observed on the bus while oe_q is set, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (load_wdata) begin
      wdata_q <= wdata;
    end
  end

endmodule
